bus_dev_port: RTL and testbench

Per-device endpoint placed between a device's stimulus/monitor side and one port of the `bs_gnrtr_n_rbtr` bus arbiter. It holds a transmit FIFO that presents `pndng`/`D_pop` to the bus and accepts the bus's `pop`. It also holds a receive FIFO that captures the bus's `push`/`D_push` deliveries for the device side to drain. One instance per device; `drvrs` instances sit around the arbiter.

---
 rtl/bus_dev_port.sv | 124 ++++++++++++
 tb/tb_bus_dev_port.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_dev_port.sv
// Per-device bus endpoint: TX FIFO toward the arbiter, RX FIFO from the arbiter, sticky error flags.
// Define BUS_DEV_PORT_RX_FILTER_EN to accept only pushes addressed to `id` or `broadcast`.
module bus_dev_port #(
    parameter int         width     = 16,
    parameter int         depth     = 8,
    parameter logic [7:0] id        = 8'h00,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [width-1:0]           wr_data,
    output logic                       tx_full,
    output logic [$clog2(depth+1)-1:0] tx_count,
    output logic                       pndng,
    output logic [width-1:0]           D_pop,
    input  logic                       pop,
    input  logic                       push,
    input  logic [width-1:0]           D_push,
    output logic                       rx_valid,
    output logic [width-1:0]           rx_data,
    input  logic                       rx_rd,
    output logic                       rx_full,
    output logic [3:0]                 err
);
    localparam int            pw       = (depth > 1) ? $clog2(depth) : 1;
    localparam int            cw       = $clog2(depth + 1);
    localparam logic [pw-1:0] last_ptr = pw'(depth - 1);
    localparam logic [cw-1:0] full_cnt = cw'(depth);

    function automatic logic [pw-1:0] next_ptr(input logic [pw-1:0] ptr);
        return (ptr == last_ptr) ? '0 : ptr + pw'(1);
    endfunction

    // ---------------- TX FIFO ----------------
    logic [width-1:0] tx_mem [depth];
    logic [pw-1:0]    tx_wr_ptr;
    logic [pw-1:0]    tx_rd_ptr;
    logic [cw-1:0]    tx_cnt;
    logic             tx_wr_ok;
    logic             tx_rd_ok;

    assign tx_full  = (tx_cnt == full_cnt);
    assign pndng    = (tx_cnt != '0);
    assign tx_count = tx_cnt;
    // NOTE: a write while full is refused even when a pop frees a slot on the same edge.
    assign tx_wr_ok = wr_en && !tx_full;
    assign tx_rd_ok = pop && pndng;
    assign D_pop    = pndng ? tx_mem[tx_rd_ptr] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_cnt    <= '0;
        end else begin
            if (tx_wr_ok) tx_wr_ptr <= next_ptr(tx_wr_ptr);
            if (tx_rd_ok) tx_rd_ptr <= next_ptr(tx_rd_ptr);
            if (tx_wr_ok && !tx_rd_ok)      tx_cnt <= tx_cnt + cw'(1);
            else if (!tx_wr_ok && tx_rd_ok) tx_cnt <= tx_cnt - cw'(1);
        end
    end

    // NOTE: storage is deliberately left unreset; the heads are masked to 0 whenever a FIFO is empty.
    always_ff @(posedge clk) begin
        if (tx_wr_ok) tx_mem[tx_wr_ptr] <= wr_data;
    end

    // ---------------- RX FIFO ----------------
    logic [width-1:0] rx_mem [depth];
    logic [pw-1:0]    rx_wr_ptr;
    logic [pw-1:0]    rx_rd_ptr;
    logic [cw-1:0]    rx_cnt;
    logic             rx_wr_ok;
    logic             rx_rd_ok;
    logic             dest_ok;

`ifdef BUS_DEV_PORT_RX_FILTER_EN
    assign dest_ok = (D_push[width-1:width-8] == id) || (D_push[width-1:width-8] == broadcast);
`else
    assign dest_ok = 1'b1;
`endif

    assign rx_full  = (rx_cnt == full_cnt);
    assign rx_valid = (rx_cnt != '0);
    assign rx_wr_ok = push && dest_ok && !rx_full;
    assign rx_rd_ok = rx_rd && rx_valid;
    assign rx_data  = rx_valid ? rx_mem[rx_rd_ptr] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_cnt    <= '0;
        end else begin
            if (rx_wr_ok) rx_wr_ptr <= next_ptr(rx_wr_ptr);
            if (rx_rd_ok) rx_rd_ptr <= next_ptr(rx_rd_ptr);
            if (rx_wr_ok && !rx_rd_ok)      rx_cnt <= rx_cnt + cw'(1);
            else if (!rx_wr_ok && rx_rd_ok) rx_cnt <= rx_cnt - cw'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rx_wr_ok) rx_mem[rx_wr_ptr] <= D_push;
    end

    // ---------------- sticky error flags ----------------
    logic [3:0] err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= '0;
        end else begin
            if (wr_en && tx_full) err_q[0] <= 1'b1;
            if (pop && !pndng)    err_q[1] <= 1'b1;
            if (push && rx_full)  err_q[2] <= 1'b1;
            // A full-FIFO drop is reported only as an overflow, never as a misroute.
            if (push && !rx_full && !dest_ok) err_q[3] <= 1'b1;
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_bus_dev_port.sv
// Scoreboard bench for bus_dev_port: directed and randomized traffic against a queue-based model.
// Build with BUS_DEV_PORT_RX_FILTER_EN defined to exercise the destination filter.
module tb_bus_dev_port;
    localparam int         W  = 16;
    localparam int         D  = 8;
    localparam logic [7:0] ID = 8'h02;
    localparam logic [7:0] BC = 8'hFF;
`ifdef BUS_DEV_PORT_RX_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic         clk     = 1'b0;
    logic         reset   = 1'b1;
    logic         wr_en   = 1'b0;
    logic         pop     = 1'b0;
    logic         push    = 1'b0;
    logic         rx_rd   = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic [W-1:0] D_push  = '0;
    logic         tx_full, pndng, rx_valid, rx_full;
    logic [3:0]   tx_count;
    logic [W-1:0] D_pop, rx_data;
    logic [3:0]   err;

    bus_dev_port #(.width(W), .depth(D), .id(ID), .broadcast(BC)) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_data(wr_data), .tx_full(tx_full), .tx_count(tx_count),
        .pndng(pndng), .D_pop(D_pop), .pop(pop),
        .push(push), .D_push(D_push),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_rd(rx_rd), .rx_full(rx_full),
        .err(err)
    );

    always #5 clk = ~clk;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] m_tx[$];
    logic [W-1:0] m_rx[$];
    logic [W-1:0] exp_tx[$];
    logic [W-1:0] exp_rx[$];
    logic [3:0]   m_err = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: whenever the DUT hands over a head word, compare it with the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (pop && pndng) begin
                if (exp_tx.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL tx_pop: DUT delivered %0h with nothing expected (t=%0t)", D_pop, $time);
                end else begin
                    check("tx_data", 32'(D_pop), 32'(exp_tx.pop_front()));
                end
            end
            if (rx_rd && rx_valid) begin
                if (exp_rx.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rx_read: DUT delivered %0h with nothing expected (t=%0t)", rx_data, $time);
                end else begin
                    check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
                end
            end
        end
    end

    task automatic check_status();
        check("tx_count", 32'(tx_count), 32'(m_tx.size()));
        check("tx_full",  32'(tx_full),  32'(m_tx.size() == D));
        check("pndng",    32'(pndng),    32'(m_tx.size() != 0));
        check("rx_valid", 32'(rx_valid), 32'(m_rx.size() != 0));
        check("rx_full",  32'(rx_full),  32'(m_rx.size() == D));
        check("err",      32'(err),      32'(m_err));
        if (m_tx.size() == 0) check("D_pop_empty", 32'(D_pop), 32'd0);
        if (m_rx.size() == 0) check("rx_data_empty", 32'(rx_data), 32'd0);
    endtask

    // One clock of stimulus; the model applies the FIFO rules to the pre-edge occupancy.
    task automatic step(input logic we, input logic [W-1:0] wd, input logic p,
                        input logic ps, input logic [W-1:0] dp, input logic rr);
        bit tx_acc;
        bit rx_acc;
        bit ok_dest;
        wr_en = we; wr_data = wd; pop = p;
        push = ps; D_push = dp; rx_rd = rr;

        tx_acc = we && (m_tx.size() < D);
        if (we && !tx_acc)             m_err[0] = 1'b1;
        if (p && m_tx.size() == 0)     m_err[1] = 1'b1;
        if (p && m_tx.size() > 0)      exp_tx.push_back(m_tx.pop_front());
        if (tx_acc)                    m_tx.push_back(wd);

        ok_dest = !FILTER || (dp[15:8] == ID) || (dp[15:8] == BC);
        if (ps) begin
            if (m_rx.size() == D) m_err[2] = 1'b1;
            else if (!ok_dest)    m_err[3] = 1'b1;
        end
        rx_acc = ps && ok_dest && (m_rx.size() < D);
        if (rr && m_rx.size() > 0)     exp_rx.push_back(m_rx.pop_front());
        if (rx_acc)                    m_rx.push_back(dp);

        @(posedge clk);
        #1;
        check_status();
    endtask

    task automatic idle();
        wr_en = 1'b0; pop = 1'b0; push = 1'b0; rx_rd = 1'b0;
        wr_data = '0; D_push = '0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int thr_w, thr_r;
        logic [7:0] dest;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_status();
        reset = 1'b0;

        // Three writes, then three pops
        step(1'b1, 16'h0301, 1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 16'h0302, 1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 16'h0303, 1'b0, 1'b0, '0, 1'b0);
        repeat (3) step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);

        // Fill TX, rejected write alongside a pop, drain with wrap, then pop on empty
        for (int i = 0; i < D; i++) step(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 16'hDEAD, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < D - 1; i++) step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);

        // RX destination handling
        step(1'b0, '0, 1'b0, 1'b1, 16'h02AA, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 16'hFFBB, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 16'h05CC, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);

        // Fill RX, overflow, then simultaneous push and read at 4 entries
        for (int i = 0; i < D; i++) step(1'b0, '0, 1'b0, 1'b1, {ID, 8'(8'h40 + i)}, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, {ID, 8'h77}, 1'b0);
        repeat (4) step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1, {BC, 8'h99}, 1'b1);
        repeat (5) step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);

        // Randomized traffic, alternating fill-heavy and drain-heavy phases
        for (int i = 0; i < 1500; i++) begin
            thr_w = ((i / 100) % 2 == 0) ? 70 : 30;
            thr_r = 100 - thr_w;
            case ($urandom_range(0, 3))
                0:       dest = ID;
                1:       dest = BC;
                2:       dest = 8'h05;
                default: dest = 8'($urandom);
            endcase
            step($urandom_range(0, 99) < thr_w, 16'($urandom), $urandom_range(0, 99) < thr_r,
                 $urandom_range(0, 99) < thr_w, {dest, 8'($urandom)}, $urandom_range(0, 99) < thr_r);
        end

        // Asynchronous reset with traffic in flight: TX=5, RX=3
        idle();
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        while (m_tx.size() > 0 || m_rx.size() > 0)
            step(1'b0, '0, m_tx.size() > 0, 1'b0, '0, m_rx.size() > 0);
        for (int i = 0; i < 5; i++)
            step(1'b1, 16'hA000 + 16'(i), 1'b0, i < 3, {ID, 8'(i)}, 1'b0);
        idle();
        reset = 1'b1;
        #2;
        m_tx.delete();
        m_rx.delete();
        m_err = '0;
        check_status();
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 16'hBEEF, 1'b0, 1'b1, {ID, 8'h5A}, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);

        check("tx_scoreboard_drained", 32'(exp_tx.size()), 32'd0);
        check("rx_scoreboard_drained", 32'(exp_rx.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
